// File: rtl/mips_dbg_pkg.sv
// Shared types and constants for the MIPS fetch-trace debug logic.
// No logic, no latency; no flow control.
// Consumers import with mips_dbg_pkg::*.
package mips_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    STOPPED = 2'd2
  } trc_state_t;

  localparam logic [1:0] MODE_FREE = 2'd0;
  localparam logic [1:0] MODE_HALT = 2'd1;
  localparam logic [1:0] MODE_FULL = 2'd2;

  // syscall encoding used as the program-end marker
  localparam logic [31:0] DEF_HALT_WORD = 32'h0000000C;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH x WIDTH register array, synchronous write and read.
// Read data appears one clock after re; write visible to reads on the next clock.
// No backpressure; the owner guarantees pointers stay in range.
module trace_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 64
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // only the read register is reset so rd_data comes up as zero
  always_ff @(posedge clock or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mips_trace_buffer.sv
// Fetch-trace recorder: captures {pc,ir} per fetch into a circular buffer, detects halt, freezes for readout.
// Capture takes effect on the next clock; rd_data/rd_valid follow an accepted rd_en by one clock.
// No backpressure on fetches: overwrite (free/halt modes) or drop-and-stop (full mode); pops only in STOPPED.
module mips_trace_buffer
  import mips_dbg_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 64,
  parameter logic [DATA_W-1:0] HALT_WORD   = DATA_W'(DEF_HALT_WORD),
  parameter int                STALL_LIMIT = 16,
  parameter int                CNT_W       = 32
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       arm,
  input  logic [1:0]                 mode,
  input  logic                       fetch_valid,
  input  logic [ADDR_W-1:0]          pc_i,
  input  logic [DATA_W-1:0]          ir_i,
  input  logic                       rd_en,
  output logic [ADDR_W+DATA_W-1:0]   rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       halted,
  output logic                       capturing,
  output logic [CNT_W-1:0]           cycle_cnt,
  output logic [CNT_W-1:0]           instr_cnt
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int RUN_W  = $clog2(STALL_LIMIT + 1) + 1;
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [RUN_W-1:0] LIMIT_R  = RUN_W'(STALL_LIMIT);

  trc_state_t         state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [ADDR_W-1:0]  prev_pc;
  logic               prev_vld;
  logic [RUN_W-1:0]   stall_run, run_next;

  logic in_cap, fetch, stall_hit, halt_hit, drop, do_write, overwrite, pop;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign capturing = (state_q == CAPTURE);

  always_comb begin
    in_cap    = (state_q == CAPTURE);
    fetch     = in_cap && fetch_valid && !arm;
    run_next  = '0;
    if (prev_vld && (pc_i == prev_pc))
      run_next = (stall_run >= LIMIT_R) ? stall_run : stall_run + 1'b1;
    stall_hit = (STALL_LIMIT != 0) && (run_next >= LIMIT_R);
    halt_hit  = fetch && ((ir_i == HALT_WORD) || stall_hit);
    drop      = fetch && full && (mode == MODE_FULL);
    do_write  = fetch && !drop;
    overwrite = do_write && full;
    pop       = (state_q == STOPPED) && rd_en && !arm && !empty;
  end

  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = CAPTURE;
    end else begin
      case (state_q)
        CAPTURE: begin
          // mode 3 is reserved and behaves as free-run, so it never stops
          if (drop)
            state_d = STOPPED;
          else if (halt_hit && (mode == MODE_HALT || mode == MODE_FULL))
            state_d = STOPPED;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      halted    <= 1'b0;
      rd_valid  <= 1'b0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
      prev_pc   <= '0;
      prev_vld  <= 1'b0;
      stall_run <= '0;
    end else if (arm) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      halted    <= 1'b0;
      rd_valid  <= 1'b0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
      prev_vld  <= 1'b0;
      stall_run <= '0;
    end else begin
      rd_valid <= pop;
      if (in_cap && (cycle_cnt != '1))
        cycle_cnt <= cycle_cnt + 1'b1;
      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (instr_cnt != '1)
          instr_cnt <= instr_cnt + 1'b1;
        // a full buffer keeps its count; the oldest entry is lost instead
        if (overwrite) begin
          rd_ptr   <= rd_ptr + 1'b1;
          overflow <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
      if (fetch) begin
        prev_pc   <= pc_i;
        prev_vld  <= 1'b1;
        stall_run <= run_next;
      end
      if (halt_hit)
        halted <= 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count - 1'b1;
      end
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_ram (
    .clock (clock),
    .rst   (rst),
    .we    (do_write),
    .waddr (wr_ptr),
    .wdata ({pc_i, ir_i}),
    .re    (pop),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Scoreboard bench for mips_trace_buffer: directed fetch/pop sequences with hand-computed expectations.
module tb_mips_trace_buffer;
  import mips_dbg_pkg::*;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic        arm = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        fetch_valid = 1'b0;
  logic [31:0] pc_i = '0;
  logic [31:0] ir_i = '0;
  logic        rd_en = 1'b0;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic [6:0]  count;
  logic        empty, full, overflow, halted, capturing;
  logic [31:0] cycle_cnt, instr_cnt;

  int nvec = 0;
  int nfail = 0;
  logic [63:0] sb[$];

  always #5 clock = ~clock;

  mips_trace_buffer dut (
    .clock       (clock),
    .rst         (rst),
    .arm         (arm),
    .mode        (mode),
    .fetch_valid (fetch_valid),
    .pc_i        (pc_i),
    .ir_i        (ir_i),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .overflow    (overflow),
    .halted      (halted),
    .capturing   (capturing),
    .cycle_cnt   (cycle_cnt),
    .instr_cnt   (instr_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!rst && rd_valid) begin
      if (sb.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL pop_unexpected: got rd_data %h expected no rd_valid", rd_data);
      end else begin
        check("pop_data", rd_data, sb.pop_front());
      end
    end
  end

  function automatic logic [63:0] entry(input int i);
    logic [31:0] pc;
    pc = 32'(i * 4);
    return {pc, 32'h2000_0000 | pc};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_arm(input logic [1:0] m);
    mode = m;
    arm  = 1'b1;
    tick();
    arm  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] ir);
    fetch_valid = 1'b1;
    pc_i = pc;
    ir_i = ir;
    tick();
    fetch_valid = 1'b0;
  endtask

  task automatic pop(input logic [63:0] e);
    sb.push_back(e);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b1;
    repeat (3) tick();
    // reset state
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_capturing", 64'(capturing), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", rd_data, 64'd0);
    check("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
    check("rst_instr_cnt", 64'(instr_cnt), 64'd0);
    check("rst_flags", {62'd0, overflow, halted}, 64'd0);
    rst = 1'b0;
    tick();

    // IDLE ignores fetches
    fetch(32'h40, 32'h1);
    check("idle_count", 64'(count), 64'd0);
    check("idle_instr", 64'(instr_cnt), 64'd0);

    // 1: halt word stops capture in mode 1
    do_arm(MODE_HALT);
    check("t1_capturing", 64'(capturing), 64'd1);
    for (int i = 0; i < 4; i++) fetch(entry(i)[63:32], entry(i)[31:0]);
    fetch(32'h10, 32'h0000000C);
    check("t1_halted", 64'(halted), 64'd1);
    check("t1_stopped", 64'(capturing), 64'd0);
    check("t1_count", 64'(count), 64'd5);
    check("t1_instr", 64'(instr_cnt), 64'd5);
    check("t1_cycles", 64'(cycle_cnt), 64'd5);
    fetch(32'h14, 32'h3);
    check("t1_stopped_fetch", 64'(count), 64'd5);
    for (int i = 0; i < 4; i++) pop(entry(i));
    pop({32'h10, 32'h0000000C});
    drain();
    check("t1_empty", 64'(empty), 64'd1);
    // 5a: pop on empty buffer
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t5_empty_rd_valid", 64'(rd_valid), 64'd0);
    check("t5_empty_count", 64'(count), 64'd0);

    // 2: free-run wraps, oldest six entries lost
    do_arm(MODE_FREE);
    for (int i = 0; i < 3; i++) fetch(entry(i)[63:32], entry(i)[31:0]);
    // 5b: rd_en during capture is ignored
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t5_cap_rd_count", 64'(count), 64'd3);
    check("t5_cap_rd_valid", 64'(rd_valid), 64'd0);
    for (int i = 3; i < 70; i++) fetch(entry(i)[63:32], entry(i)[31:0]);
    check("t2_overflow", 64'(overflow), 64'd1);
    check("t2_count", 64'(count), 64'd64);
    check("t2_full", 64'(full), 64'd1);
    check("t2_instr", 64'(instr_cnt), 64'd70);
    check("t2_halted", 64'(halted), 64'd0);
    check("t2_capturing", 64'(capturing), 64'd1);
    // switching to mode 2 while full drops the next fetch and stops
    mode = MODE_FULL;
    fetch(32'h999, 32'h5);
    check("t2_stopped", 64'(capturing), 64'd0);
    check("t2_instr_after_drop", 64'(instr_cnt), 64'd70);
    check("t2_count_after_drop", 64'(count), 64'd64);
    for (int i = 6; i < 70; i++) pop(entry(i));
    drain();

    // 3: stop when full
    do_arm(MODE_FULL);
    check("t3_rearm_overflow", 64'(overflow), 64'd0);
    for (int i = 0; i < 66; i++) fetch(entry(i)[63:32], entry(i)[31:0]);
    check("t3_stopped", 64'(capturing), 64'd0);
    check("t3_count", 64'(count), 64'd64);
    check("t3_instr", 64'(instr_cnt), 64'd64);
    check("t3_halted", 64'(halted), 64'd0);
    for (int i = 0; i < 64; i++) pop(entry(i));
    drain();
    check("t3_empty", 64'(empty), 64'd1);

    // 4: PC stall of 16 identical repeats
    do_arm(MODE_HALT);
    for (int i = 0; i < 20; i++) fetch(32'h20, 32'h1000_FFFF);
    check("t4_halted", 64'(halted), 64'd1);
    check("t4_count", 64'(count), 64'd17);
    check("t4_instr", 64'(instr_cnt), 64'd17);
    check("t4_stopped", 64'(capturing), 64'd0);
    for (int i = 0; i < 17; i++) pop({32'h20, 32'h1000_FFFF});
    drain();

    // 6: async reset mid-capture, then re-arm
    do_arm(MODE_FREE);
    for (int i = 0; i < 3; i++) fetch(entry(i)[63:32], entry(i)[31:0]);
    check("t6_pre_capturing", 64'(capturing), 64'd1);
    check("t6_pre_cycles", 64'(cycle_cnt), 64'd3);
    #3 rst = 1'b1;
    #1;
    check("t6_rst_count", 64'(count), 64'd0);
    check("t6_rst_empty", 64'(empty), 64'd1);
    check("t6_rst_capturing", 64'(capturing), 64'd0);
    check("t6_rst_cycles", 64'(cycle_cnt), 64'd0);
    check("t6_rst_instr", 64'(instr_cnt), 64'd0);
    #2 rst = 1'b0;
    tick();
    check("t6_idle_after_rst", 64'(capturing), 64'd0);
    do_arm(MODE_FREE);
    check("t6_rearm_cycles0", 64'(cycle_cnt), 64'd0);
    tick();
    check("t6_rearm_cycles1", 64'(cycle_cnt), 64'd1);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
